// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding and baud divider helpers
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_e;
  function automatic int clog2(input int n);
    int r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return (r < 1) ? 1 : r;
  endfunction
  function automatic int calc_div(input int clk_hz, input int baud, input int os);
    return (clk_hz + baud * os / 2) / (baud * os);
  endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: oversampling tick, one pulse every DIV clocks, restartable
module uart_baud_tick import uart_pkg::*; #(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic rst_n_i,
  input  logic clr_i,
  output logic tick_o
);
  localparam int W = clog2(DIV);
  logic [W-1:0] cnt;
  assign tick_o = cnt == W'(DIV - 1);
  always_ff @(posedge clk or negedge rst_n_i)
    if (!rst_n_i) cnt <= '0;
    else cnt <= (clr_i || tick_o) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer: 8N1 oversampling receiver with majority vote and one-entry holding register
module uart_rx_deserializer import uart_pkg::*; #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n_i,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  input  logic       clr_ovr_i,
  output logic       busy_o
);
  localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int KW  = clog2(OVERSAMPLE);
  localparam int M   = OVERSAMPLE / 2;
  rx_state_e state, state_n;
  logic s1, s2, hist, tick, v0, v1;
  logic fall, vote, decide, bit_end, start_clr, stop_done, ferr_set, load, ovr_set;
  logic [KW-1:0] k;
  logic [2:0] bit_cnt;
  logic [7:0] sh;
  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk(clk), .rst_n_i(rst_n_i), .clr_i(start_clr), .tick_o(tick)
  );
  assign busy_o = state != IDLE;
  always_comb begin
    fall      = hist & ~s2;
    vote      = (v0 & v1) | (v0 & s2) | (v1 & s2);
    decide    = tick && k == KW'(M + 1);
    bit_end   = tick && k == KW'(OVERSAMPLE - 1);
    start_clr = state == IDLE && fall;
    state_n   = state;
    stop_done = 1'b0;
    ferr_set  = 1'b0;
    case (state)
      IDLE:  state_n = fall ? START : IDLE;
      START: state_n = (decide && vote) ? IDLE : bit_end ? DATA : START;
      DATA:  state_n = (bit_end && bit_cnt == 3'd7) ? STOP : DATA;
      STOP: begin
        state_n   = decide ? (vote ? IDLE : BREAK) : STOP;
        stop_done = decide & vote;
        ferr_set  = decide & ~vote;
      end
      BREAK: state_n = s2 ? IDLE : BREAK;
      default: state_n = IDLE;
    endcase
    load    = stop_done & (~valid_o | ready_i);
    ovr_set = stop_done & valid_o & ~ready_i;
  end
  always_ff @(posedge clk or negedge rst_n_i)
    if (!rst_n_i) begin
      state       <= IDLE;
      {s1, s2, hist} <= 3'b111;
      k           <= '0;
      {v0, v1}    <= 2'b11;
      bit_cnt     <= '0;
      sh          <= '0;
      data_o      <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      state       <= state_n;
      {s1, s2, hist} <= {rx_i, s1, s2};
      k           <= start_clr ? '0 : !tick ? k : (k == KW'(OVERSAMPLE - 1)) ? '0 : k + 1'b1;
      v0          <= (tick && k == KW'(M - 1)) ? s2 : v0;
      v1          <= (tick && k == KW'(M)) ? s2 : v1;
      bit_cnt     <= (state == START) ? '0 : (state == DATA && bit_end) ? bit_cnt + 3'd1 : bit_cnt;
      sh          <= (state == DATA && decide) ? {vote, sh[7:1]} : sh;
      data_o      <= load ? sh : data_o;
      valid_o     <= load | (valid_o & ~ready_i);
      frame_err_o <= ferr_set;
      overrun_o   <= ovr_set | (overrun_o & ~clr_ovr_i);
    end
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb_uart_rx_deserializer: directed frames at 115200 baud / 50 MHz with hand-computed expectations
module tb_uart_rx_deserializer;
  logic clk = 1'b0, rst_n_i = 1'b0, rx_i = 1'b1, ready_i = 1'b0, clr_ovr_i = 1'b0;
  logic [7:0] data_o, last_data;
  logic valid_o, frame_err_o, overrun_o, busy_o, vprev = 1'b0;
  int cyc = 0, vcnt = 0, fcnt = 0, acc = 0, rise_cyc = 0, t0 = 0;
  int tests = 0, failed = 0;
  int v0, f0, a0;
  uart_rx_deserializer dut (
    .clk(clk), .rst_n_i(rst_n_i), .rx_i(rx_i), .data_o(data_o), .valid_o(valid_o),
    .ready_i(ready_i), .frame_err_o(frame_err_o), .overrun_o(overrun_o),
    .clr_ovr_i(clr_ovr_i), .busy_o(busy_o)
  );
  always #10 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (valid_o) vcnt++;
    if (valid_o && !vprev) rise_cyc = cyc;
    if (valid_o && ready_i) begin last_data = data_o; acc++; end
    if (frame_err_o) fcnt++;
    vprev = valid_o;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask
  task automatic send(input logic [7:0] d, input int n, input logic stop);
    t0 = cyc;
    rx_i = 1'b0;
    step(n);
    for (int i = 0; i < 8; i++) begin rx_i = d[i]; step(n); end
    rx_i = stop;
    step(n);
  endtask
  initial begin
    step(5);
    chk("rst_data", data_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_ferr", frame_err_o, 0);
    chk("rst_ovr", overrun_o, 0);
    chk("rst_busy", busy_o, 0);
    rst_n_i = 1'b1;
    step(20);
    // 1: single byte, consumer always ready
    ready_i = 1'b1;
    v0 = vcnt; f0 = fcnt; a0 = acc;
    send(8'hA5, 432, 1'b1);
    step(20);
    chk("t1_data", last_data, 8'hA5);
    chk("t1_valid_cycles", vcnt - v0, 1);
    chk("t1_accepts", acc - a0, 1);
    chk("t1_latency", rise_cyc - t0, 4161);
    chk("t1_ferr", fcnt - f0, 0);
    chk("t1_ovr", overrun_o, 0);
    // 2: back-to-back with consumer stalled
    ready_i = 1'b0;
    send(8'h55, 432, 1'b1);
    send(8'h0F, 432, 1'b1);
    step(20);
    chk("t2_data_held", data_o, 8'h55);
    chk("t2_valid", valid_o, 1);
    chk("t2_ovr_set", overrun_o, 1);
    clr_ovr_i = 1'b1;
    step(1);
    clr_ovr_i = 1'b0;
    chk("t2_ovr_clr", overrun_o, 0);
    chk("t2_valid_kept", valid_o, 1);
    ready_i = 1'b1;
    step(1);
    chk("t2_valid_drop", valid_o, 0);
    chk("t2_accepted", last_data, 8'h55);
    step(50);
    // 3: 135-clk glitch is a false start
    v0 = vcnt; f0 = fcnt;
    rx_i = 1'b0;
    step(60);
    chk("t3_busy_in_glitch", busy_o, 1);
    step(75);
    rx_i = 1'b1;
    step(400);
    chk("t3_busy", busy_o, 0);
    chk("t3_valid", valid_o, 0);
    chk("t3_no_byte", vcnt - v0, 0);
    chk("t3_no_ferr", fcnt - f0, 0);
    // 4: bad stop bit then held-low line
    v0 = vcnt; f0 = fcnt; a0 = acc;
    send(8'h3C, 432, 1'b0);
    step(1296);
    chk("t4_busy_break", busy_o, 1);
    rx_i = 1'b1;
    step(50);
    chk("t4_busy_after", busy_o, 0);
    chk("t4_ferr_pulses", fcnt - f0, 1);
    chk("t4_no_byte", vcnt - v0, 0);
    send(8'h81, 432, 1'b1);
    step(20);
    chk("t4_recover_data", last_data, 8'h81);
    chk("t4_recover_cnt", acc - a0, 1);
    // 5: +/-3% baud skew
    a0 = acc;
    send(8'hC3, 419, 1'b1);
    step(200);
    chk("t5_fast_data", last_data, 8'hC3);
    chk("t5_fast_cnt", acc - a0, 1);
    a0 = acc;
    send(8'hC3, 445, 1'b1);
    step(200);
    chk("t5_slow_data", last_data, 8'hC3);
    chk("t5_slow_cnt", acc - a0, 1);
    // 6: reset during bit 4 of 0x7E
    v0 = vcnt; f0 = fcnt;
    rx_i = 1'b0;
    step(432);
    for (int i = 0; i < 4; i++) begin rx_i = (i != 0); step(432); end
    rx_i = 1'b1;
    step(200);
    chk("t6_busy_before", busy_o, 1);
    rst_n_i = 1'b0;
    #1;
    chk("t6_rst_busy", busy_o, 0);
    chk("t6_rst_data", data_o, 0);
    chk("t6_rst_valid", valid_o, 0);
    step(5);
    rst_n_i = 1'b1;
    step(500);
    chk("t6_no_byte", vcnt - v0, 0);
    chk("t6_no_ferr", fcnt - f0, 0);
    a0 = acc;
    send(8'h7E, 432, 1'b1);
    step(20);
    chk("t6_next_data", last_data, 8'h7E);
    chk("t6_next_cnt", acc - a0, 1);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
